// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind the UART receiver with an APB-style register window.
// Registers: DATA (pop), STATUS, CTRL (flush / clear sticky flags), THRESH (irq level).
module uart_rx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             sel,
   input  logic             enable,
   input  logic             write,
   input  logic [11:2]      addr,
   input  logic [31:0]      data_out,
   output logic [31:0]      data_in,
   output logic             ready,
   output logic             irq
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [15:0] DEPTH_W = 16'(DEPTH);

   localparam logic [9:0] ADDR_DATA   = 10'd0;
   localparam logic [9:0] ADDR_STATUS = 10'd1;
   localparam logic [9:0] ADDR_CTRL   = 10'd2;
   localparam logic [9:0] ADDR_THRESH = 10'd3;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic             overflow;
   logic             underflow;
   logic [15:0]      thresh;
   logic [15:0]      thresh_sat;

   logic             empty;
   logic             full;
   logic             access;
   logic             rd_acc;
   logic             wr_acc;
   logic             pop;
   logic             push;
   logic             flush;
   logic             clr_flags;
   logic             ovf_set;
   logic             unf_set;
   logic             thr_wr;
   logic             unused_bits;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign ready = 1'b1;
   assign unused_bits = ^data_out[31:16];

   // Bus decode and FIFO event qualification
   always_comb begin
      access    = sel & enable;
      rd_acc    = access & ~write;
      wr_acc    = access & write;
      flush     = wr_acc & (addr == ADDR_CTRL) & data_out[0];
      clr_flags = wr_acc & (addr == ADDR_CTRL) & data_out[1];
      thr_wr    = wr_acc & (addr == ADDR_THRESH);
      pop       = rd_acc & (addr == ADDR_DATA) & ~empty;
      unf_set   = rd_acc & (addr == ADDR_DATA) & empty;
      // A pop in the same cycle frees the slot a full FIFO needs for the push
      push      = wr_valid & ~flush & (~full | pop);
      ovf_set   = wr_valid & ~flush & full & ~pop;
      thresh_sat = (data_out[15:0] > DEPTH_W) ? DEPTH_W : data_out[15:0];
   end

   // Occupancy update
   always_comb begin
      count_nxt = count;
      if (flush) begin
         count_nxt = '0;
      end else if (push && !pop) begin
         count_nxt = count + CW'(1);
      end else if (pop && !push) begin
         count_nxt = count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         thresh    <= '0;
      end else begin
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count_nxt;
         // A flag event in the same cycle as a clear is kept
         overflow  <= (overflow  & ~clr_flags) | ovf_set;
         underflow <= (underflow & ~clr_flags) | unf_set;
         if (thr_wr) thresh <= thresh_sat;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr] <= wr_data;
   end

   // Read mux, driven only during a read access
   always_comb begin
      data_in = '0;
      if (rd_acc) begin
         case (addr)
            ADDR_DATA: begin
               if (!empty) data_in = 32'h8000_0000 | 32'(mem[rd_ptr]);
            end
            ADDR_STATUS: begin
               data_in[15:0] = 16'(count);
               data_in[16]   = empty;
               data_in[17]   = full;
               data_in[18]   = overflow;
               data_in[19]   = underflow;
            end
            ADDR_THRESH: data_in = 32'(thresh);
            default:     data_in = '0;
         endcase
      end
   end

   assign irq = (thresh != '0) && (16'(count) >= thresh);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed and random traffic against a queue-based model,
// with a negedge monitor draining an expected-response scoreboard.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int WIDTH = 10;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_valid;
   logic [WIDTH-1:0] wr_data;
   logic             sel;
   logic             enable;
   logic             write;
   logic [9:0]       addr;
   logic [31:0]      data_out;
   logic [31:0]      data_in;
   logic             ready;
   logic             irq;

   int checks = 0;
   int errors = 0;

   logic [31:0]      exp_rd_q[$];
   bit               exp_irq_q[$];
   bit               mon_on = 1'b0;

   logic [WIDTH-1:0] mq[$];
   bit               m_ovf;
   bit               m_unf;
   int               m_thr;

   uart_rx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
      .sel(sel), .enable(enable), .write(write), .addr(addr),
      .data_out(data_out), .data_in(data_in), .ready(ready), .irq(irq)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rd_expect(logic [9:0] a);
      logic [31:0] e;
      e = '0;
      case (a)
         10'd0: if (mq.size() != 0) e = 32'h8000_0000 | 32'(mq[0]);
         10'd1: begin
            e[15:0] = 16'(mq.size());
            e[16]   = (mq.size() == 0);
            e[17]   = (mq.size() == DEPTH);
            e[18]   = m_ovf;
            e[19]   = m_unf;
         end
         10'd3:   e = 32'(m_thr);
         default: e = '0;
      endcase
      return e;
   endfunction

   // One clock cycle: drive, record expectations, advance the model, wait the edge
   task automatic cycle(input bit r, input bit wv, input logic [WIDTH-1:0] wd,
                        input bit acc, input bit wr, input logic [9:0] a,
                        input logic [31:0] d);
      bit full_b, is_pop, unf_ev, ovf_ev, flush, clr;
      rst = r; wr_valid = wv; wr_data = wd;
      sel = acc; enable = acc; write = wr; addr = a; data_out = d;
      exp_irq_q.push_back(m_thr != 0 && mq.size() >= m_thr);
      if (acc && !wr) exp_rd_q.push_back(rd_expect(a));
      if (r) begin
         mq.delete();
         m_ovf = 0; m_unf = 0; m_thr = 0;
      end else begin
         full_b = (mq.size() == DEPTH);
         is_pop = acc && !wr && a == 10'd0 && mq.size() != 0;
         unf_ev = acc && !wr && a == 10'd0 && mq.size() == 0;
         flush  = acc && wr && a == 10'd2 && d[0];
         clr    = acc && wr && a == 10'd2 && d[1];
         ovf_ev = 0;
         if (is_pop) void'(mq.pop_front());
         if (wv && !flush) begin
            if (!full_b || is_pop) mq.push_back(wd);
            else ovf_ev = 1;
         end
         if (flush) mq.delete();
         if (clr) begin m_ovf = 0; m_unf = 0; end
         m_ovf = m_ovf | ovf_ev;
         m_unf = m_unf | unf_ev;
         if (acc && wr && a == 10'd3)
            m_thr = (int'(d[15:0]) > DEPTH) ? DEPTH : int'(d[15:0]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(0, 0, '0, 0, 0, 10'd0, 32'd0);
   endtask
   task automatic push(input logic [WIDTH-1:0] w);
      cycle(0, 1, w, 0, 0, 10'd0, 32'd0);
   endtask
   task automatic rd(input logic [9:0] a);
      cycle(0, 0, '0, 1, 0, a, 32'd0);
   endtask
   task automatic wrr(input logic [9:0] a, input logic [31:0] d);
      cycle(0, 0, '0, 1, 1, a, d);
   endtask

   // Monitor: compares every cycle's outputs with the oldest expectations
   always @(negedge clk) begin : monitor
      logic [31:0] e;
      bit ei;
      if (mon_on) begin
         if (exp_irq_q.size() == 0) begin
            errors++;
            $display("FAIL sb_irq_underrun: no expected irq value queued");
         end else begin
            ei = exp_irq_q.pop_front();
            checks++;
            if (irq !== ei) begin
               errors++;
               $display("FAIL irq @%0t: got %b expected %b", $time, irq, ei);
            end
         end
         if (sel && enable && !write) begin
            if (exp_rd_q.size() == 0) begin
               errors++;
               $display("FAIL sb_rd_underrun: read with no expectation queued");
            end else begin
               e = exp_rd_q.pop_front();
               checks++;
               if (data_in !== e) begin
                  errors++;
                  $display("FAIL data_in addr=%0d @%0t: got %08h expected %08h",
                           addr, $time, data_in, e);
               end
            end
         end else begin
            checks++;
            if (data_in !== 32'd0) begin
               errors++;
               $display("FAIL data_in_idle @%0t: got %08h expected 00000000", $time, data_in);
            end
         end
         checks++;
         if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready @%0t: got %b expected 1", $time, ready);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      rst = 1; wr_valid = 0; wr_data = '0; sel = 0; enable = 0;
      write = 0; addr = '0; data_out = '0;
      m_ovf = 0; m_unf = 0; m_thr = 0;
      repeat (2) @(posedge clk);
      #1;
      mon_on = 1'b1;

      // Reset state, empty read
      cycle(1, 0, '0, 0, 0, 10'd0, 32'd0);
      rd(10'd1); rd(10'd0); rd(10'd1);
      wrr(10'd2, 32'h2);

      // Two words in, two out
      push(10'h155); push(10'h2AA);
      rd(10'd1); rd(10'd0); rd(10'd0); rd(10'd1);

      // Overflow: 17 pushes into 16 entries
      for (int i = 0; i < 17; i++) push(10'(i));
      rd(10'd1);
      for (int i = 0; i < 17; i++) rd(10'd0);
      rd(10'd1);
      wrr(10'd2, 32'h2);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 16; i++) push(10'(32'h100 + i));
      cycle(0, 1, 10'h3FF, 1, 0, 10'd0, 32'd0);
      rd(10'd1);
      for (int i = 0; i < 16; i++) rd(10'd0);
      rd(10'd1);

      // Threshold and irq
      wrr(10'd3, 32'd3); rd(10'd3);
      push(10'h011); push(10'h022); push(10'h033);
      idle(); idle();
      rd(10'd0); idle();
      push(10'h044); idle();
      wrr(10'd3, 32'd0); idle();
      wrr(10'd3, 32'hFFFF_0064); rd(10'd3);
      wrr(10'd3, 32'd0);
      wrr(10'd7, 32'hFFFF_FFFF); rd(10'd7); rd(10'd2);
      wrr(10'd2, 32'h1);

      // Flush and clear colliding with a push
      for (int i = 0; i < 5; i++) push(10'(32'h200 + i));
      cycle(0, 1, 10'h1AB, 1, 1, 10'd2, 32'h3);
      rd(10'd1); idle(); rd(10'd0);

      // Reset mid-fill
      wrr(10'd3, 32'd5);
      for (int i = 0; i < 4; i++) push(10'(32'h300 + i));
      cycle(1, 1, 10'h0AA, 0, 0, 10'd0, 32'd0);
      rd(10'd1); rd(10'd3);

      // Random traffic with varying fill pressure
      for (int i = 0; i < 3000; i++) begin
         int unsigned pw;
         int unsigned op;
         bit wv;
         logic [WIDTH-1:0] wd;
         case ((i / 200) % 3)
            0:       pw = 20;
            1:       pw = 50;
            default: pw = 92;
         endcase
         wv = ($urandom_range(99, 0) < pw);
         wd = WIDTH'($urandom);
         op = $urandom_range(99, 0);
         if ($urandom_range(599, 0) == 0)
            cycle(1, wv, wd, 0, 0, 10'd0, 32'd0);
         else if (op < 35)
            cycle(0, wv, wd, 1, 0, 10'd0, 32'd0);
         else if (op < 50)
            cycle(0, wv, wd, 1, 0, 10'd1, 32'd0);
         else if (op < 53)
            cycle(0, wv, wd, 1, 1, 10'd2, 32'($urandom_range(3, 0)));
         else if (op < 57)
            cycle(0, wv, wd, 1, 1, 10'd3,
                  ($urandom_range(9, 0) == 0) ? $urandom : 32'($urandom_range(20, 0)));
         else if (op < 61)
            cycle(0, wv, wd, 1, 0, 10'd3, 32'd0);
         else if (op < 64)
            cycle(0, wv, wd, 1, $urandom_range(1, 0) == 1,
                  10'($urandom_range(1023, 4)), $urandom);
         else if (op < 66)
            cycle(0, wv, wd, 1, 0, 10'd2, 32'd0);
         else
            cycle(0, wv, wd, 0, 0, 10'd0, 32'd0);
      end

      mon_on = 1'b0;
      checks++;
      if (exp_rd_q.size() != 0 || exp_irq_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: rd=%0d irq=%0d expected 0 0",
                  exp_rd_q.size(), exp_irq_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It captures each received 10-bit word (raw 8b10b symbol or zero-extended binary byte) into a circular FIFO. It exposes the FIFO to the processor through the same APB-style register interface the UART uses. The FIFO decouples bus read latency from line rate and raises a level interrupt when a programmable fill threshold is reached.

## Interface
- DEPTH, 16, number of FIFO entries; power of two, minimum 2
- WIDTH, 10, width of each received word; maximum 16
- clk  input  1  single clock for all logic
- rst  input  1  synchronous active-high reset
- wr_valid  input  1  one-cycle strobe from the receiver: wr_data holds a complete word
- wr_data  input  WIDTH  received word
- sel  input  1  peripheral select
- enable  input  1  access phase
- write  input  1  1 = bus write, 0 = bus read
- addr  input  [11:2]  word address
- data_out  input  32  bus write data
- data_in  output  32  bus read data; combinational during the access phase
- ready  output  1  constant 1 (zero wait states)
- irq  output  1  level interrupt: fill level ≥ threshold

## Operation
- Registers are selected by word address: 0 = DATA (RO, pop), 1 = STATUS (RO), 2 = CTRL (WO), 3 = THRESH (RW). All other addresses read 0, and writes to them are ignored.
- An access is any cycle with sel & enable = 1.
- Each access cycle is one transaction. Masters hold enable for exactly one cycle.
- DATA read:
  - Non-empty FIFO: data_in = {1'b1, zeros, head word in [WIDTH-1:0]}. The read pointer advances at the clock edge ending the access.
  - Empty FIFO: data_in = 0, no pointer change, and the sticky underflow bit is set.
- STATUS read:
  - [15:0] count, zero-extended
  - [16] empty
  - [17] full
  - [18] overflow (sticky)
  - [19] underflow (sticky)
  - [31:20] 0
- CTRL write:
  - bit0 = 1 flushes the FIFO: pointers and count go to 0.
  - bit1 = 1 clears both sticky flags.
  - Both bits may be set in one write.
- THRESH write: the threshold register takes data_out[15:0], saturated to DEPTH. THRESH read returns this value.
- Push: wr_valid = 1 with FIFO not full writes wr_data at the write pointer. Pointers wrap modulo DEPTH.
- Push when full with no simultaneous pop: the word is dropped and overflow is set. FIFO contents are unchanged.
- Push and DATA-pop in the same cycle:
  - FIFO full: both occur and count is unchanged. No overflow.
  - FIFO empty: the pop is treated as an empty read (underflow set, data_in = 0) and the push is stored. Count goes to 1.
- Flush in the same cycle as wr_valid: flush wins and the incoming word is discarded. Overflow is not set by that word.
- irq = (threshold != 0) & (count >= threshold). It is derived combinationally from registered state.

## Timing
- Reset values: count 0, pointers 0, overflow 0, underflow 0, threshold 0. Consequently irq = 0, data_in = 0 (no access), ready = 1.
- A word pushed at edge N is visible in STATUS and readable via DATA in the cycle after edge N.
- A pop takes effect at the edge ending the access. The next access sees the new head and count.
- irq follows count with no added latency: it rises the cycle after the push that reaches the threshold, and falls the cycle after the pop or flush that drops below it.
- rst asserted mid-operation discards all contents and flags at the next edge. A bus access in that same cycle has no side effect.
- Count width is clog2(DEPTH)+1, so the value DEPTH is representable. Full = (count == DEPTH).

## Test plan
- Reset, then read STATUS → 0x0001_0000 (empty). irq = 0. DATA read → 0x0000_0000; STATUS then reads 0x0009_0000.
- Push 0x155 and 0x2AA, then read DATA twice → 0x8000_0155, then 0x8000_02AA. STATUS count 2 → 0, empty set.
- Push 17 words 0x000..0x010 with DEPTH = 16 → STATUS 0x0006_0010 (full, overflow). DATA reads return 0x000..0x00F in order; 0x010 is lost.
- Fill to full, then apply wr_valid = 0x3FF with a simultaneous DATA read → read returns the oldest word. Count stays 16, overflow stays 0, and 0x3FF is the last word popped.
- Write THRESH = 3, push 3 words → irq rises the cycle after the third push. One DATA read → irq falls the next cycle. Write THRESH = 0 → irq = 0.
- With 5 words queued, write CTRL = 0x3 in the same cycle as wr_valid → STATUS 0x0001_0000 and the pushed word is discarded. Also assert rst mid-fill → STATUS 0x0001_0000 and THRESH reads 0.
